// File: rtl/aes_key_schedule_seq.sv
// AES key expansion, one 32-bit word per clock, for AES-128/192/256.
// A single shared SubWord unit serves both the RotWord and the Nk=8 mid-key steps.
// The expanded schedule is held in a word store and read out one round key at a time
// through a registered port.
// Optional build macro: AES_KS_REV_READ_EN adds rk_rev, which reads round keys in
// decryption order (Nr - rk_idx).
module aes_key_schedule_seq #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [0:255] key,
  input  logic [3:0]   rk_idx,
`ifdef AES_KS_REV_READ_EN
  input  logic         rk_rev,
`endif
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         key_err,
  output logic [0:127] rk
);

  localparam int NR_MAX = (MAX_KEY_BITS / 32) + 6;
  localparam int WORDS  = 4 * (NR_MAX + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   i_q, i_d;
  logic [2:0]   mod_q, mod_d;     // i mod Nk, tracked incrementally
  logic [3:0]   rc_q, rc_d;       // i / Nk, the Rcon index
  logic [3:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic         kv_q, kv_d;
  logic         kerr_q, kerr_d;
  logic [0:127] rk_q, rk_d;
  logic [31:0]  w_q [WORDS];

  logic [3:0]   nk_req;
  logic         len_ok;
  logic         load, wr_en;
  logic [31:0]  prev_w, back_w, sub_in, sub_out, temp_w, new_w;
  logic [3:0]   ridx;
  logic [5:0]   base;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Requested key geometry and whether this build supports it.
  always_comb begin
    case (key_len)
      2'd0:    nk_req = 4'd4;
      2'd1:    nk_req = 4'd6;
      default: nk_req = 4'd8;
    endcase
    len_ok = (key_len != 2'd3) && ((int'(nk_req) * 32) <= MAX_KEY_BITS);
  end

  // Next word of the schedule through the single shared SubWord unit.
  always_comb begin
    prev_w  = w_q[i_q - 6'd1];
    back_w  = w_q[i_q - {2'b00, nk_q}];
    sub_in  = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (mod_q == 3'd0)
      temp_w = sub_out ^ {rcon(rc_q), 24'h000000};
    else if (nk_q == 4'd8 && mod_q == 3'd4)
      temp_w = sub_out;
    else
      temp_w = prev_w;
    new_w = back_w ^ temp_w;
  end

  // Next-state logic for IDLE / EXPAND / DONE.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    mod_d   = mod_q;
    rc_d    = rc_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    kv_d    = kv_q;
    kerr_d  = 1'b0;
    load    = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            load    = 1'b1;
            nk_d    = nk_req;
            nr_d    = nk_req + 4'd6;
            i_d     = {2'b00, nk_req};
            mod_d   = 3'd0;
            rc_d    = 4'd1;
            kv_d    = 1'b0;
            state_d = EXPAND;
          end else begin
            kerr_d = 1'b1;
          end
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        i_d   = i_q + 6'd1;
        mod_d = ({1'b0, mod_q} == nk_q - 4'd1) ? 3'd0 : mod_q + 3'd1;
        rc_d  = (mod_q == 3'd0) ? rc_q + 4'd1 : rc_q;
        if (i_q == {nr_q, 2'b11}) begin
          kv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      mod_q   <= '0;
      rc_q    <= '0;
      nk_q    <= 4'd4;
      nr_q    <= 4'd10;
      kv_q    <= 1'b0;
      kerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      mod_q   <= mod_d;
      rc_q    <= rc_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      kv_q    <= kv_d;
      kerr_q  <= kerr_d;
    end
  end

  // Word store: contents are masked by keys_valid, so no reset is needed.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < 8; j++)
        if (4'(j) < nk_req) w_q[j] <= key[32*j +: 32];
    end else if (wr_en) begin
      w_q[i_q] <= new_w;
    end
  end

  // Round-key read mux; the range check always uses the raw rk_idx.
  always_comb begin
`ifdef AES_KS_REV_READ_EN
    ridx = rk_rev ? (nr_q - rk_idx) : rk_idx;
`else
    ridx = rk_idx;
`endif
    base = {ridx, 2'b00};
    rk_d = '0;
    if (kv_q && (rk_idx <= nr_q))
      rk_d = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
  end

  // Registered round-key output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rk_q <= '0;
    else     rk_q <= rk_d;
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign keys_valid = kv_q;
  assign key_err    = kerr_q;
  assign rk         = rk_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq using FIPS-197 key expansion vectors.
// A second instance built with MAX_KEY_BITS=128 covers the oversize-key rejection.
module tb_aes_key_schedule_seq;

  logic         clk, rst, start;
  logic [1:0]   key_len;
  logic [0:255] key;
  logic [3:0]   rk_idx;
  logic         busy, done, keys_valid, key_err;
  logic [0:127] rk;
  logic         start2;
  logic [1:0]   key_len2;
  logic         busy2, done2, kv2, kerr2;
  logic [0:127] rk2;
`ifdef AES_KS_REV_READ_EN
  logic         rk_rev;
`endif

  int n_cmp, n_bad;
  logic [127:0] exp_q[$];
  string        nm_q[$];

  localparam logic [0:255] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [0:255] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] R256_3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_schedule_seq dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key), .rk_idx(rk_idx),
`ifdef AES_KS_REV_READ_EN
    .rk_rev(rk_rev),
`endif
    .busy(busy), .done(done), .keys_valid(keys_valid), .key_err(key_err), .rk(rk)
  );

  aes_key_schedule_seq #(.MAX_KEY_BITS(128)) dut128 (
    .clk(clk), .rst(rst), .start(start2), .key_len(key_len2), .key(key), .rk_idx(rk_idx),
`ifdef AES_KS_REV_READ_EN
    .rk_rev(rk_rev),
`endif
    .busy(busy2), .done(done2), .keys_valid(kv2), .key_err(kerr2), .rk(rk2)
  );

  always #5 clk = ~clk;

  // Drive a read index and record what the registered rk must show one cycle later.
  task automatic sb_drive(input logic [3:0] idx, input logic [127:0] e, input string nm);
    rk_idx = idx;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Start an expansion and follow it to completion, timing start-sample to done-sample.
  task automatic run_expand(input string nm, input logic [1:0] kl, input logic [0:255] k,
                            input int exp_lat);
    int cnt;
    @(negedge clk);
    start = 1'b1; key_len = kl; key = k;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    n_cmp++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s accept: busy=%b keys_valid=%b, required 1/0", nm, busy, keys_valid);
    end
    while (done !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== exp_lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, required %0d", nm, cnt, exp_lat);
    end
    n_cmp++;
    if (keys_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done-cycle: keys_valid=%b busy=%b, required 1/1", nm, keys_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || keys_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s after-done: done=%b busy=%b keys_valid=%b, required 0/0/1",
               nm, done, busy, keys_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, keys_valid, key_err} !== 4'b0 || rk !== 128'h0) begin
      n_bad++;
      $display("FAIL reset: busy/done/kv/err=%b rk=%h, required 0000/0",
               {busy, done, keys_valid, key_err}, rk);
    end
    n_cmp++;
    if ({busy2, done2, kv2, kerr2} !== 4'b0 || rk2 !== 128'h0) begin
      n_bad++;
      $display("FAIL reset128: busy/done/kv/err=%b rk=%h, required 0000/0",
               {busy2, done2, kv2, kerr2}, rk2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_aes128();
    logic [3:0]   ix[6];
    logic [127:0] ex[6];
    logic [127:0] e;
    string        nm;
    ix = '{4'd0, 4'd1, 4'd2, 4'd10, 4'd11, 4'd15};
    ex = '{K128[0:127], R128_1, R128_2, R128_10, 128'h0, 128'h0};
    run_expand("aes128", 2'd0, K128, 41);
    for (int j = 0; j < 6; j++) begin
      sb_drive(ix[j], ex[j], $sformatf("aes128 rk[%0d]", ix[j]));
      @(negedge clk);
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (rk !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk, e);
      end
    end
`ifdef AES_KS_REV_READ_EN
    rk_rev = 1'b1;
    ix[0] = 4'd0;  ex[0] = R128_10;
    ix[1] = 4'd9;  ex[1] = R128_1;
    ix[2] = 4'd10; ex[2] = K128[0:127];
    ix[3] = 4'd11; ex[3] = 128'h0;
    for (int j = 0; j < 4; j++) begin
      sb_drive(ix[j], ex[j], $sformatf("aes128 rev rk[%0d]", ix[j]));
      @(negedge clk);
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (rk !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk, e);
      end
    end
    rk_rev = 1'b0;
`endif
  endtask

  task automatic test_reserved();
    logic [127:0] e;
    string        nm;
    sb_drive(4'd10, R128_10, "reserved rk held");
    @(negedge clk);
    start = 1'b1; key_len = 2'd3; key = K256;
    @(negedge clk);
    start = 1'b0; key_len = 2'd0;
    e = exp_q.pop_front(); nm = nm_q.pop_front();
    n_cmp++;
    if (key_err !== 1'b1 || busy !== 1'b0 || keys_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reserved pulse: key_err=%b busy=%b keys_valid=%b, required 1/0/1",
               key_err, busy, keys_valid);
    end
    n_cmp++;
    if (rk !== e) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, rk, e);
    end
    @(negedge clk);
    n_cmp++;
    if (key_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reserved one-cycle: key_err=%b busy=%b, required 0/0", key_err, busy);
    end
  endtask

  task automatic test_max128();
    int           cnt;
    logic [127:0] e;
    string        nm;
    logic [1:0]   bad_len[2];
    bad_len = '{2'd2, 2'd1};
    @(negedge clk);
    start2 = 1'b1; key_len2 = 2'd0; key = K128;
    @(negedge clk);
    start2 = 1'b0;
    cnt = 1;
    while (done2 !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_cmp++;
    if (cnt !== 41) begin
      n_bad++;
      $display("FAIL max128 latency: got %0d cycles, required 41", cnt);
    end
    for (int j = 0; j < 2; j++) begin
      sb_drive(4'd10, R128_10, $sformatf("max128 rk held len%0d", bad_len[j]));
      @(negedge clk);
      start2 = 1'b1; key_len2 = bad_len[j]; key = K256;
      @(negedge clk);
      start2 = 1'b0;
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (kerr2 !== 1'b1 || busy2 !== 1'b0 || kv2 !== 1'b1) begin
        n_bad++;
        $display("FAIL max128 reject len%0d: key_err=%b busy=%b keys_valid=%b, required 1/0/1",
                 bad_len[j], kerr2, busy2, kv2);
      end
      n_cmp++;
      if (rk2 !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk2, e);
      end
      @(negedge clk);
      n_cmp++;
      if (kerr2 !== 1'b0 || busy2 !== 1'b0) begin
        n_bad++;
        $display("FAIL max128 one-cycle len%0d: key_err=%b busy=%b, required 0/0",
                 bad_len[j], kerr2, busy2);
      end
    end
  endtask

  task automatic test_aes192();
    logic [3:0]   ix[3];
    logic [127:0] ex[3];
    logic [127:0] e;
    string        nm;
    ix = '{4'd0, 4'd12, 4'd13};
    ex = '{K192[0:127], R192_12, 128'h0};
    run_expand("aes192", 2'd1, K192, 47);
    for (int j = 0; j < 3; j++) begin
      sb_drive(ix[j], ex[j], $sformatf("aes192 rk[%0d]", ix[j]));
      @(negedge clk);
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (rk !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk, e);
      end
    end
  endtask

  task automatic test_aes256();
    logic [3:0]   ix[6];
    logic [127:0] ex[6];
    logic [127:0] e;
    string        nm;
    ix = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd14, 4'd15};
    ex = '{K256[0:127], K256[128:255], R256_2, R256_3, R256_14, 128'h0};
    run_expand("aes256", 2'd2, K256, 53);
    for (int j = 0; j < 6; j++) begin
      sb_drive(ix[j], ex[j], $sformatf("aes256 rk[%0d]", ix[j]));
      @(negedge clk);
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (rk !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0]   ix[2];
    logic [127:0] ex[2];
    logic [127:0] e;
    string        nm;
    ix = '{4'd10, 4'd1};
    ex = '{R128_10, R128_1};
    @(negedge clk);
    start = 1'b1; key_len = 2'd0; key = K128;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; key_len = 2'd2; key = K256;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (key_err !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort busy-start: key_err=%b busy=%b, required 0/1", key_err, busy);
    end
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, keys_valid, key_err} !== 4'b0 || rk !== 128'h0) begin
      n_bad++;
      $display("FAIL abort reset: busy/done/kv/err=%b rk=%h, required 0000/0",
               {busy, done, keys_valid, key_err}, rk);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort idle: busy=%b done=%b, required 0/0", busy, done);
    end
    run_expand("abort restart", 2'd0, K128, 41);
    for (int j = 0; j < 2; j++) begin
      sb_drive(ix[j], ex[j], $sformatf("abort rk[%0d]", ix[j]));
      @(negedge clk);
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      n_cmp++;
      if (rk !== e) begin
        n_bad++;
        $display("FAIL %s: got %h, required %h", nm, rk, e);
      end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_idx = 4'd0;
    start2 = 1'b0; key_len2 = 2'd0;
`ifdef AES_KS_REV_READ_EN
    rk_rev = 1'b0;
`endif
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_aes128();
    test_reserved();
    test_max128();
    test_aes192();
    test_aes256();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
